mdu_sched: RTL

- Multiply/divide execution controller behind the MDU issue queue; takes one issued MDU op per cycle via valid/ready.
- Steers MUL* into a fixed-latency multiply pipeline and DIV*/MOD* into an iterative divider (sub-module).
- Arbitrates both result sources onto one valid/ready result port feeding the writeback FIFO.
- Handles sign fix-up, divide-by-zero/overflow shortcuts and flush.

---
 rtl/mdu_sched_pkg.sv | 43 ++++
 rtl/mdu_sched_if.sv | 26 ++
 rtl/mdu_sched_div_iter.sv | 83 ++++++++
 rtl/mdu_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared types and constants for the MDU scheduler and its iterative divider.
package mdu_sched_pkg;

   localparam int DATA_W   = 32;
   localparam int ROB_W    = 6;
   localparam int DIV_ITER = 32;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ROB_W-1:0]  rob_id_t;

   typedef enum logic [2:0] {
      OP_MUL   = 3'd0,
      OP_MULH  = 3'd1,
      OP_MULHU = 3'd2,
      OP_RSVD  = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_MOD   = 3'd6,
      OP_MODU  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // One 64-bit product of (optionally) sign-extended operands covers all three
   // multiply flavours; the reserved encoding falls through to the low word.
   function automatic word_t mul_result(mdu_op_e op, word_t a, word_t b);
      logic             sx;
      logic [2*DATA_W-1:0] ext_a;
      logic [2*DATA_W-1:0] ext_b;
      logic [2*DATA_W-1:0] prod;
      sx    = (op == OP_MULH);
      ext_a = {{DATA_W{sx & a[DATA_W-1]}}, a};
      ext_b = {{DATA_W{sx & b[DATA_W-1]}}, b};
      prod  = ext_a * ext_b;
      if (op == OP_MULH || op == OP_MULHU) return prod[2*DATA_W-1:DATA_W];
      return prod[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Issue-side request and writeback-side result handshakes of the MDU scheduler.
interface mdu_sched_if;

   logic                     req_valid;
   logic                     req_ready;
   mdu_sched_pkg::mdu_op_e   req_op;
   mdu_sched_pkg::word_t     req_src0;
   mdu_sched_pkg::word_t     req_src1;
   mdu_sched_pkg::rob_id_t   req_rob_id;

   logic                     res_valid;
   logic                     res_ready;
   mdu_sched_pkg::word_t     res_data;
   mdu_sched_pkg::rob_id_t   res_rob_id;

   modport master (
      output req_valid, req_op, req_src0, req_src1, req_rob_id, res_ready,
      input  req_ready, res_valid, res_data, res_rob_id
   );

   modport slave (
      input  req_valid, req_op, req_src0, req_src1, req_rob_id, res_ready,
      output req_ready, res_valid, res_data, res_rob_id
   );

endinterface

// File: rtl/mdu_sched_div_iter.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
module mdu_div_iter
   import mdu_sched_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start_i,
   input  logic  kill_i,
   input  word_t dividend_i,
   input  word_t divisor_i,
   output logic  busy_o,
   output logic  done_o,
   output word_t quot_o,
   output word_t rem_o
);

   localparam int CNT_W = $clog2(DIV_ITER + 1);

   word_t            rem_q, rem_d;
   word_t            quot_q, quot_d;
   word_t            dsr_q, dsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [DATA_W:0]  rem_sh;
   logic [DATA_W:0]  diff;
   word_t            rem_step;
   word_t            quot_step;

   always_comb begin
      rem_sh = {rem_q, quot_q[DATA_W-1]};
      diff   = rem_sh - {1'b0, dsr_q};
      if (diff[DATA_W]) begin
         rem_step  = rem_sh[DATA_W-1:0];
         quot_step = {quot_q[DATA_W-2:0], 1'b0};
      end else begin
         rem_step  = diff[DATA_W-1:0];
         quot_step = {quot_q[DATA_W-2:0], 1'b1};
      end
   end

   always_comb begin
      rem_d  = rem_q;
      quot_d = quot_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (kill_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         rem_d  = '0;
         quot_d = dividend_i;
         dsr_d  = divisor_i;
         cnt_d  = CNT_W'(DIV_ITER);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d  = rem_step;
         quot_d = quot_step;
         cnt_d  = cnt_q - 1'b1;
         busy_d = (cnt_q != CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
   end

   // The final step is exposed combinationally so the owner can capture it
   // on the same edge the last bit is produced.
   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNT_W'(1)) && !kill_i;
   assign quot_o = quot_step;
   assign rem_o  = rem_step;

endmodule

// File: rtl/mdu_sched.sv
// MDU execution controller: multiply pipe, iterative divide FSM, result arbiter.
//   state    | meaning
//   DIV_IDLE | divider free, may accept a div/mod op
//   DIV_RUN  | iterating 32 cycles in mdu_div_iter
//   DIV_DONE | signed-fixed result held until the result port grants it
module mdu_sched
   import mdu_sched_pkg::*;
#(
   parameter int MUL_STAGES = 2
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   mdu_sched_if.slave   bus,
   output logic         div_busy_o
);

   mdu_op_e         op;
   logic            op_is_div;
   logic            op_signed;
   logic            live;
   logic            req_ready;
   logic            acc_mul;
   logic            acc_div;

   logic [MUL_STAGES-1:0] mul_v_q, mul_v_d;
   word_t           mul_data_q [MUL_STAGES];
   word_t           mul_data_d [MUL_STAGES];
   rob_id_t         mul_tag_q  [MUL_STAGES];
   rob_id_t         mul_tag_d  [MUL_STAGES];
   logic            mul_last_v;
   logic            mul_adv;
   logic            mul_grant;

   div_state_e      div_state_q, div_state_d;
   word_t           div_res_q, div_res_d;
   rob_id_t         div_tag_q, div_tag_d;
   logic            div_mod_q, div_mod_d;
   logic            div_qneg_q, div_qneg_d;
   logic            div_rneg_q, div_rneg_d;
   logic            div_done;
   logic            div_grant;
   logic            neg_a, neg_b;
   logic            div_zero, div_ovf;
   word_t           abs_a, abs_b;
   logic            iter_busy, iter_done;
   word_t           iter_quot, iter_rem;

   logic            res_valid;
   logic            grant;

   assign op         = bus.req_op;
   assign op_is_div  = op[2];
   assign op_signed  = (op == OP_DIV) || (op == OP_MOD);
   assign live       = rst_n && !flush_i;

   assign mul_last_v = mul_v_q[MUL_STAGES-1];
   assign div_done   = (div_state_q == DIV_DONE);
   assign res_valid  = div_done || mul_last_v;
   assign grant      = res_valid && bus.res_ready;
   assign div_grant  = grant && div_done;
   assign mul_grant  = grant && !div_done;
   assign mul_adv    = !mul_last_v || mul_grant;

   assign req_ready  = live && (op_is_div ? (div_state_q == DIV_IDLE && !iter_busy) : mul_adv);
   assign acc_mul    = bus.req_valid && req_ready && !op_is_div;
   assign acc_div    = bus.req_valid && req_ready && op_is_div;

   // The whole pipe moves or freezes together, so bubbles keep their slots.
   always_comb begin
      mul_v_d    = mul_v_q;
      mul_data_d = mul_data_q;
      mul_tag_d  = mul_tag_q;
      if (mul_adv) begin
         mul_v_d[0]    = acc_mul;
         mul_data_d[0] = mul_result(op, bus.req_src0, bus.req_src1);
         mul_tag_d[0]  = bus.req_rob_id;
         for (int i = 1; i < MUL_STAGES; i++) begin
            mul_v_d[i]    = mul_v_q[i-1];
            mul_data_d[i] = mul_data_q[i-1];
            mul_tag_d[i]  = mul_tag_q[i-1];
         end
      end
      if (flush_i) mul_v_d = '0;
   end

   assign neg_a    = op_signed && bus.req_src0[DATA_W-1];
   assign neg_b    = op_signed && bus.req_src1[DATA_W-1];
   assign abs_a    = neg_a ? -bus.req_src0 : bus.req_src0;
   assign abs_b    = neg_b ? -bus.req_src1 : bus.req_src1;
   assign div_zero = (bus.req_src1 == '0);
   assign div_ovf  = op_signed && (bus.req_src0 == {1'b1, {(DATA_W-1){1'b0}}})
                     && (bus.req_src1 == '1);

   mdu_div_iter u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (acc_div && !div_zero && !div_ovf),
      .kill_i     (flush_i),
      .dividend_i (abs_a),
      .divisor_i  (abs_b),
      .busy_o     (iter_busy),
      .done_o     (iter_done),
      .quot_o     (iter_quot),
      .rem_o      (iter_rem)
   );

   always_comb begin
      div_state_d = div_state_q;
      div_res_d   = div_res_q;
      div_tag_d   = div_tag_q;
      div_mod_d   = div_mod_q;
      div_qneg_d  = div_qneg_q;
      div_rneg_d  = div_rneg_q;
      unique case (div_state_q)
         DIV_IDLE: begin
            if (acc_div) begin
               div_tag_d  = bus.req_rob_id;
               div_mod_d  = op[1];
               div_qneg_d = neg_a ^ neg_b;
               div_rneg_d = neg_a;
               if (div_zero) begin
                  div_res_d   = op[1] ? bus.req_src0 : '1;
                  div_state_d = DIV_DONE;
               end else if (div_ovf) begin
                  div_res_d   = op[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
                  div_state_d = DIV_DONE;
               end else begin
                  div_state_d = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            if (iter_done) begin
               if (div_mod_q) div_res_d = div_rneg_q ? -iter_rem : iter_rem;
               else           div_res_d = div_qneg_q ? -iter_quot : iter_quot;
               div_state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (div_grant) div_state_d = DIV_IDLE;
         end
         default: div_state_d = DIV_IDLE;
      endcase
      if (flush_i) div_state_d = DIV_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mul_v_q     <= '0;
         div_state_q <= DIV_IDLE;
      end else begin
         mul_v_q     <= mul_v_d;
         div_state_q <= div_state_d;
      end
      mul_data_q <= mul_data_d;
      mul_tag_q  <= mul_tag_d;
      div_res_q  <= div_res_d;
      div_tag_q  <= div_tag_d;
      div_mod_q  <= div_mod_d;
      div_qneg_q <= div_qneg_d;
      div_rneg_q <= div_rneg_d;
   end

   // Divider wins so it can take the next div op; the mul tail simply stalls.
   assign bus.req_ready  = req_ready;
   assign bus.res_valid  = res_valid;
   assign bus.res_data   = div_done   ? div_res_q :
                           mul_last_v ? mul_data_q[MUL_STAGES-1] : '0;
   assign bus.res_rob_id = div_done   ? div_tag_q :
                           mul_last_v ? mul_tag_q[MUL_STAGES-1] : '0;
   assign div_busy_o     = (div_state_q != DIV_IDLE);

endmodule
